// File: rtl/freq_sched_pkg.sv
// freq_sched_pkg: shared state encoding and symbol constants for the frame scheduler.
package freq_sched_pkg;
  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_REQ, WAIT_ACK} state_t;
  localparam logic [3:0] IDLE_SYM = 4'hF;
  localparam int NUM_SYM = 10;
endpackage

// File: rtl/freq_rr_arb.sv
// freq_rr_arb: combinational round-robin pick, searching from ptr+1 and wrapping.
module freq_rr_arb
  import freq_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IW-1:0]      idx,
  output logic               any
);
  // Walk offsets from farthest to nearest so the nearest valid source wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (valid[IW'((int'(ptr) + i) % NUM_REQ)]) begin
        idx = IW'((int'(ptr) + i) % NUM_REQ);
        any = 1'b1;
      end
    pick = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/freq_frame_sched.sv
// freq_frame_sched: round-robin frame scheduler feeding the shared freqcount datapath.
// Optional WAIT_ACK watchdog enabled by defining FREQ_SCHED_TIMEOUT_EN.
module freq_frame_sched
  import freq_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_FRAME = 255,
  parameter int TIMEOUT   = 1023,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_FRAME + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   src_valid,
  input  logic [4*NUM_REQ-1:0] src_data,
  input  logic [NUM_REQ-1:0]   src_last,
  output logic [NUM_REQ-1:0]   src_ready,
  output logic                 fc_start,
  output logic                 fc_start_done,
  output logic [3:0]           fc_data,
  input  logic                 fc_req_coding,
  input  logic                 fc_ack_coding,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 trunc_err,
  output logic                 timeout_err
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_FRAME < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("freq_frame_sched: parameter out of range");
  end
  state_t state, nxt;
  logic [IW-1:0] grant, ptr, pick_idx;
  logic [NUM_REQ-1:0] grant_oh, pick;
  logic [CW-1:0] cnt;
  logic any, take, fin, tmo;
  freq_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid(src_valid),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (any)
  );
  assign take       = state == STREAM && src_valid[grant];
  assign fin        = take && (src_last[grant] || cnt == CW'(MAX_FRAME - 1));
  assign src_ready  = state == STREAM ? grant_oh : '0;
  assign busy       = state != IDLE;
  assign grant_id   = grant;
  assign frame_done = state == WAIT_ACK && fc_ack_coding;
`ifdef FREQ_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= state == WAIT_ACK ? tcnt + 1'b1 : '0;
  assign tmo         = state == WAIT_ACK && !fc_ack_coding && tcnt == TW'(TIMEOUT - 1);
  assign timeout_err = tmo;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = any ? START : IDLE;
      START:    nxt = STREAM;
      STREAM:   nxt = fin ? WAIT_REQ : STREAM;
      WAIT_REQ: nxt = fc_req_coding ? WAIT_ACK : WAIT_REQ;
      WAIT_ACK: nxt = (fc_ack_coding || tmo) ? IDLE : WAIT_ACK;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // freqcount-facing outputs are registered, so fc_start leads the first symbol by one cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant         <= '0;
      grant_oh      <= '0;
      ptr           <= '0;
      cnt           <= '0;
      fc_start      <= 1'b0;
      fc_start_done <= 1'b0;
      fc_data       <= IDLE_SYM;
      trunc_err     <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        grant    <= pick_idx;
        grant_oh <= pick;
      end
      if (frame_done || tmo) ptr <= grant;
      cnt           <= fin ? '0 : cnt + CW'(take);
      fc_start      <= state == START;
      fc_start_done <= fin;
      fc_data       <= take ? src_data[{grant, 2'b00} +: 4] : IDLE_SYM;
      trunc_err     <= fin && !src_last[grant];
    end
endmodule

// File: tb/tb_freq_frame_sched.sv
// tb_freq_frame_sched: directed scenarios for the frame scheduler with a freqcount-side monitor.
module tb_freq_frame_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] src_valid, src_last, src_ready;
  logic [7:0] src_data;
  logic fc_start, fc_start_done, fc_req_coding, fc_ack_coding;
  logic [3:0] fc_data;
  logic [0:0] grant_id;
  logic busy, frame_done, trunc_err, timeout_err;
  int checks = 0, failures = 0;
  int cyc = 0, n_start = 0, n_sd = 0, n_tr = 0, n_trsd = 0, run = 0, last_len = 0;
  int t_start = 0, t_first = 0;
  int hist[16] = '{default: 0};
  logic first_pend = 1'b0;
  logic [3:0] sd_data = 4'h0;

  freq_frame_sched #(.NUM_REQ(2), .MAX_FRAME(255), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .fc_start(fc_start),
    .fc_start_done(fc_start_done), .fc_data(fc_data), .fc_req_coding(fc_req_coding),
    .fc_ack_coding(fc_ack_coding), .grant_id(grant_id), .busy(busy),
    .frame_done(frame_done), .trunc_err(trunc_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // freqcount-side view: symbol histogram, frame lengths and pulse counts
  always @(negedge clk) begin
    cyc++;
    if (fc_start) begin n_start++; run = 0; t_start = cyc; first_pend = 1'b1; end
    if (fc_data != 4'hF) begin
      hist[fc_data]++;
      run++;
      if (first_pend) begin t_first = cyc; first_pend = 1'b0; end
    end
    if (fc_start_done) begin n_sd++; sd_data = fc_data; last_len = run; if (trunc_err) n_trsd++; end
    if (trunc_err) n_tr++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [3:0] d, input logic l);
    src_valid[s] = 1'b1;
    src_data[4*s +: 4] = d;
    src_last[s] = l;
    for (int k = 0; k < 1000; k++) begin
      if (src_ready[s]) begin tick(); return; end
      tick();
    end
    checks++; failures++;
    $display("FAIL push_src%0d: ready=0 after 1000 cycles, want 1", s);
  endtask

  task automatic idle_src(input int s);
    src_valid[s] = 1'b0;
    src_last[s] = 1'b0;
  endtask

  task automatic wait_start(input int base);
    for (int k = 0; k < 200 && n_start <= base; k++) tick();
    if (n_start <= base) begin
      checks++; failures++;
      $display("FAIL wait_start: fc_start count=%0d want >%0d", n_start, base);
    end
  endtask

  // Plays the freqcount/coder side: req two cycles after start_done, ack dly cycles later.
  task automatic ack_frame(input int base, input int dly, output logic fd, output int len, output logic [3:0] d);
    fd = 1'b0; len = -1; d = 4'h0;
    for (int k = 0; k < 2000 && n_sd <= base; k++) tick();
    if (n_sd <= base) begin
      checks++; failures++;
      $display("FAIL ack_frame: fc_start_done count=%0d want >%0d", n_sd, base);
      return;
    end
    len = last_len; d = sd_data;
    tick(); tick();
    fc_req_coding = 1'b1;
    repeat (dly) tick();
    fc_ack_coding = 1'b1;
    #1 fd = frame_done;
    tick();
    fc_ack_coding = 1'b0;
    fc_req_coding = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_valid = '0; src_last = '0; src_data = '0;
    fc_req_coding = 1'b0; fc_ack_coding = 1'b0;
    tick();
    checks++; if (fc_data !== 4'hF) begin failures++; $display("FAIL reset_fc_data: got %h want f", fc_data); end
    checks++; if ({busy, src_ready, fc_start, fc_start_done, grant_id, frame_done, trunc_err, timeout_err} !== 9'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 0", {busy, src_ready, fc_start, fc_start_done, grant_id, frame_done, trunc_err, timeout_err});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int h3 = hist[3], h7 = hist[7], h9 = hist[9], base = n_sd, len;
    logic fd; logic [3:0] d;
    push(0, 4'd3, 1'b0); push(0, 4'd3, 1'b0); push(0, 4'd7, 1'b0); push(0, 4'd9, 1'b1);
    idle_src(0);
    ack_frame(base, 3, fd, len, d);
    checks++; if (fd !== 1'b1) begin failures++; $display("FAIL single_frame_done: got %b want 1", fd); end
    checks++; if (d !== 4'd9) begin failures++; $display("FAIL single_last_sym: got %0d want 9", d); end
    checks++; if (len !== 4) begin failures++; $display("FAIL single_len: got %0d want 4", len); end
    checks++; if (t_first - t_start !== 1) begin failures++; $display("FAIL single_start_lead: got %0d want 1", t_first - t_start); end
    checks++; if (hist[3] - h3 !== 2 || hist[7] - h7 !== 1 || hist[9] - h9 !== 1) begin
      failures++; $display("FAIL single_counts: got 3:%0d 7:%0d 9:%0d want 2 1 1", hist[3] - h3, hist[7] - h7, hist[9] - h9);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_g[3] = '{1, 0, 1};
    int len;
    logic fd; logic [3:0] d;
    rst_n = 1'b0;
    src_valid = 2'b11; src_last = 2'b11; src_data = 8'h52;
    tick();
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int st = n_start, sd = n_sd;
      wait_start(st);
      checks++; if (grant_id !== 1'(exp_g[f])) begin failures++; $display("FAIL rr_grant%0d: got %0d want %0d", f, grant_id, exp_g[f]); end
      checks++; if (src_ready !== 2'(1 << exp_g[f])) begin failures++; $display("FAIL rr_ready%0d: got %b want %b", f, src_ready, 2'(1 << exp_g[f])); end
      tick();
      checks++; if (src_ready !== 2'b00) begin failures++; $display("FAIL rr_ready_wait%0d: got %b want 00", f, src_ready); end
      ack_frame(sd, 2, fd, len, d);
      checks++; if (fd !== 1'b1 || d !== (exp_g[f] == 1 ? 4'd5 : 4'd2)) begin
        failures++; $display("FAIL rr_frame%0d: frame_done=%b sym=%0d want 1 %0d", f, fd, d, exp_g[f] == 1 ? 5 : 2);
      end
    end
    idle_src(0); idle_src(1);
    tick();
  endtask

  task automatic test_gap();
    int h1 = hist[1], h2 = hist[2], h4 = hist[4], base = n_sd, len, gaps = 0;
    logic fd; logic [3:0] d;
    push(0, 4'd1, 1'b0); push(0, 4'd2, 1'b0);
    idle_src(0);
    repeat (4) begin tick(); if (fc_data === 4'hF) gaps++; end
    push(0, 4'd4, 1'b1);
    idle_src(0);
    ack_frame(base, 1, fd, len, d);
    checks++; if (gaps !== 4) begin failures++; $display("FAIL gap_idle_sym: got %0d idle cycles want 4", gaps); end
    checks++; if (hist[1] - h1 !== 1 || hist[2] - h2 !== 1 || hist[4] - h4 !== 1 || len !== 3) begin
      failures++; $display("FAIL gap_counts: got 1:%0d 2:%0d 4:%0d len %0d want 1 1 1 3", hist[1] - h1, hist[2] - h2, hist[4] - h4, len);
    end
    checks++; if (fd !== 1'b1 || d !== 4'd4) begin failures++; $display("FAIL gap_done: frame_done=%b sym=%0d want 1 4", fd, d); end
  endtask

  task automatic test_truncate();
    int base = n_sd, tr0 = n_tr, trsd0 = n_trsd, len1, len2;
    logic fd1, fd2; logic [3:0] d1, d2;
    fork
      for (int i = 0; i < 300; i++) push(0, 4'(i % 10), i == 299);
      begin
        ack_frame(base, 1, fd1, len1, d1);
        ack_frame(base + 1, 1, fd2, len2, d2);
      end
    join
    idle_src(0);
    checks++; if (len1 !== 255 || d1 !== 4'd4) begin failures++; $display("FAIL trunc_first: len %0d sym %0d want 255 4", len1, d1); end
    checks++; if (n_tr - tr0 !== 1 || n_trsd - trsd0 !== 1) begin
      failures++; $display("FAIL trunc_err: pulses %0d with_done %0d want 1 1", n_tr - tr0, n_trsd - trsd0);
    end
    checks++; if (len2 !== 45 || d2 !== 4'd9) begin failures++; $display("FAIL trunc_rest: len %0d sym %0d want 45 9", len2, d2); end
    checks++; if (fd1 !== 1'b1 || fd2 !== 1'b1) begin failures++; $display("FAIL trunc_done: got %b%b want 11", fd1, fd2); end
  endtask

  task automatic test_reset_stream();
    int st = n_start, h6, base, len;
    logic fd; logic [3:0] d;
    src_valid[1] = 1'b1; src_data[7:4] = 4'd3; src_last[1] = 1'b0;
    wait_start(st);
    tick(); tick();
    checks++; if (busy !== 1'b1 || grant_id !== 1'b1) begin failures++; $display("FAIL rst_pre: busy=%b grant=%0d want 1 1", busy, grant_id); end
    rst_n = 1'b0;
    #1;
    checks++; if (fc_data !== 4'hF) begin failures++; $display("FAIL rst_mid_fc_data: got %h want f", fc_data); end
    checks++; if ({busy, src_ready, fc_start, fc_start_done, grant_id, frame_done, trunc_err, timeout_err} !== 9'b0) begin
      failures++; $display("FAIL rst_mid_outputs: got %b want 0", {busy, src_ready, fc_start, fc_start_done, grant_id, frame_done, trunc_err, timeout_err});
    end
    idle_src(1);
    tick();
    rst_n = 1'b1;
    tick();
    st = n_start; h6 = hist[6]; base = n_sd;
    push(0, 4'd6, 1'b1);
    idle_src(0);
    checks++; if (grant_id !== 1'b0 || n_start - st !== 1) begin
      failures++; $display("FAIL rst_restart: grant=%0d starts=%0d want 0 1", grant_id, n_start - st);
    end
    ack_frame(base, 1, fd, len, d);
    checks++; if (fd !== 1'b1 || len !== 1 || hist[6] - h6 !== 1) begin
      failures++; $display("FAIL rst_frame: done=%b len=%0d cnt6=%0d want 1 1 1", fd, len, hist[6] - h6);
    end
  endtask

  task automatic test_timeout();
    int st, base, len;
    logic fd; logic [3:0] d;
    push(1, 4'd8, 1'b1);
    idle_src(1);
    tick(); tick();
    fc_req_coding = 1'b1;
`ifdef FREQ_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (timeout_err !== (k == 8) || frame_done !== 1'b0) begin
        failures++; $display("FAIL timeout_cycle%0d: timeout_err=%b frame_done=%b want %b 0", k, timeout_err, frame_done, k == 8);
      end
    end
    tick();
    fc_req_coding = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: busy=%b want 0", busy); end
    st = n_start; base = n_sd;
    src_valid = 2'b11; src_last = 2'b11; src_data = 8'h21;
    wait_start(st);
    checks++; if (grant_id !== 1'b0 || src_ready !== 2'b01) begin
      failures++; $display("FAIL timeout_next_grant: grant=%0d ready=%b want 0 01", grant_id, src_ready);
    end
    tick();
    idle_src(0); idle_src(1);
    ack_frame(base, 1, fd, len, d);
    checks++; if (fd !== 1'b1 || d !== 4'd1) begin failures++; $display("FAIL timeout_after: done=%b sym=%0d want 1 1", fd, d); end
`else
    st = 0;
    repeat (20) begin tick(); if (busy === 1'b1 && timeout_err === 1'b0 && frame_done === 1'b0) st++; end
    checks++; if (st !== 20) begin failures++; $display("FAIL no_timeout_hold: busy cycles %0d want 20", st); end
    base = n_sd;
    fc_ack_coding = 1'b1;
    #1 fd = frame_done;
    tick();
    fc_ack_coding = 1'b0;
    fc_req_coding = 1'b0;
    checks++; if (fd !== 1'b1 || busy !== 1'b0 || n_sd !== base) begin
      failures++; $display("FAIL no_timeout_ack: done=%b busy=%b want 1 0", fd, busy);
    end
    len = 0; d = 4'h0;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_truncate();
    test_reset_stream();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
